// File: rtl/dircc_node_mem_tx_dma_pkg.sv
// dircc_tx_dma_pkg: CSR offsets, CTRL/STATUS bit positions and FSM state codes for the TX DMA
package dircc_tx_dma_pkg;
    localparam logic [1:0] CSR_SRC  = 2'd0;
    localparam logic [1:0] CSR_LEN  = 2'd1;
    localparam logic [1:0] CSR_DEST = 2'd2;
    localparam logic [1:0] CSR_CTRL = 2'd3;
    localparam int CTRL_GO     = 0;
    localparam int CTRL_DONE   = 1;
    localparam int CTRL_ERR    = 2;
    localparam int CTRL_IRQ_EN = 8;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HDR    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;
endpackage

// File: rtl/dircc_node_mem_tx_dma_if.sv
// dircc_node_mem_tx_dma_if: CSR slave, memory port-2 master and flit stream bundle
// master = DMA side (drives csr_readdata, irq, mem_*, tx_* except tx_ready); slave = surroundings
interface dircc_node_mem_tx_dma_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [1:0]        csr_address;
    logic              csr_read;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;
    logic              irq;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_sop;
    logic              tx_eop;
    modport master (
        input  csr_address, csr_read, csr_write, csr_writedata, mem_readdata, tx_ready,
        output csr_readdata, irq, mem_address, mem_chipselect, mem_clken, mem_write,
               tx_data, tx_valid, tx_sop, tx_eop
    );
    modport slave (
        output csr_address, csr_read, csr_write, csr_writedata, mem_readdata, tx_ready,
        input  csr_readdata, irq, mem_address, mem_chipselect, mem_clken, mem_write,
               tx_data, tx_valid, tx_sop, tx_eop
    );
endinterface

// File: rtl/dircc_node_mem_tx_dma_skid_buf2.sv
// dircc_skid_buf2: 2-entry FIFO absorbing memory read latency
// ports: push_i/data_i write side, pop_i read side, head_o oldest entry, count_o occupancy (all registered)
module dircc_skid_buf2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);
    logic [DATA_W-1:0] e0_q, e1_q;
    logic [1:0]        cnt_q, slot;
    assign slot    = cnt_q - 2'(pop_i);
    assign head_o  = e0_q;
    assign count_o = cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= (push_i && slot == 2'd0) ? data_i : pop_i ? e1_q : e0_q;
            e1_q  <= (push_i && slot == 2'd1) ? data_i : e1_q;
            cnt_q <= slot + 2'(push_i);
        end
    end
endmodule

// File: rtl/dircc_node_mem_tx_dma.sv
// dircc_node_mem_tx_dma: CSR-programmed DMA streaming a header flit plus LEN memory words to the NoC
// ports: clk, reset_n (async, active low), bus (master modport: CSR slave, memory port 2, tx flit stream)
module dircc_node_mem_tx_dma
    import dircc_tx_dma_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 15000,
    parameter int LEN_W     = 14
) (
    input logic                   clk,
    input logic                   reset_n,
    dircc_node_mem_tx_dma_if.master bus
);
    logic [1:0]        state_q, state_d, cnt;
    logic [ADDR_W-1:0] src_q, addr_q;
    logic [LEN_W-1:0]  len_q, iss_q, out_q;
    logic [15:0]       dest_q;
    logic [DATA_W-1:0] head;
    logic [31:0]       rdata_q, rdata_d;
    logic [2:0]        occ;
    logic done_q, done_d, err_q, err_d, en_q, en_d, irq_q, infl_q;
    logic busy, ctrl_wr, cfg_wr, go, hs, pop, issue, unused_wd;
    assign unused_wd = ^bus.csr_writedata;
    assign busy    = state_q != S_IDLE;
    assign ctrl_wr = bus.csr_write && bus.csr_address == CSR_CTRL;
    assign cfg_wr  = bus.csr_write && !busy;
    assign go      = ctrl_wr && bus.csr_writedata[CTRL_GO] && !busy;
    assign bus.tx_sop   = state_q == S_HDR;
    assign bus.tx_valid = bus.tx_sop || (state_q == S_STREAM && cnt != 2'd0);
    assign bus.tx_eop   = state_q == S_STREAM && cnt != 2'd0 && out_q == LEN_W'(1);
    assign bus.tx_data  = bus.tx_sop ? DATA_W'(dest_q) : bus.tx_valid ? head : '0;
    assign hs  = bus.tx_valid && bus.tx_ready;
    assign pop = state_q == S_STREAM && hs;
    // occupancy after this cycle's pop; keeps buffered + in-flight within the 2 entries
    assign occ   = 3'(cnt) + 3'(infl_q) - 3'(pop);
    assign issue = (state_q == S_HDR || state_q == S_STREAM) && iss_q != '0 && cnt != 2'd2 && occ < 3'd2;
    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_clken      = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.csr_readdata   = rdata_q;
    assign bus.irq            = irq_q;
    always_comb begin
        state_d = state_q == S_IDLE   ? ((go && len_q != '0) ? S_HDR : S_IDLE) :
                  state_q == S_HDR    ? (hs ? S_STREAM : S_HDR) :
                  state_q == S_STREAM ? ((hs && bus.tx_eop) ? S_FIN : S_STREAM) : S_IDLE;
        done_d  = state_q == S_FIN || (done_q && !(ctrl_wr && bus.csr_writedata[CTRL_DONE]));
        err_d   = (go && len_q == '0) || (err_q && !(ctrl_wr && bus.csr_writedata[CTRL_ERR]));
        en_d    = ctrl_wr ? bus.csr_writedata[CTRL_IRQ_EN] : en_q;
        rdata_d = !bus.csr_read                ? '0 :
                  bus.csr_address == CSR_SRC  ? 32'(src_q) :
                  bus.csr_address == CSR_LEN  ? 32'(len_q) :
                  bus.csr_address == CSR_DEST ? 32'(dest_q) :
                  {23'd0, en_q, 5'd0, err_q, done_q, busy};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            len_q   <= '0;
            dest_q  <= '0;
            addr_q  <= '0;
            iss_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            irq_q   <= 1'b0;
            infl_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            irq_q   <= done_d && en_d;
            infl_q  <= issue;
            rdata_q <= rdata_d;
            if (cfg_wr && bus.csr_address == CSR_SRC) src_q <= bus.csr_writedata[ADDR_W-1:0];
            if (cfg_wr && bus.csr_address == CSR_LEN) len_q <= bus.csr_writedata[LEN_W-1:0];
            if (cfg_wr && bus.csr_address == CSR_DEST) dest_q <= bus.csr_writedata[15:0];
            addr_q <= go ? src_q : issue ? (addr_q == ADDR_W'(MEM_WORDS - 1) ? '0 : addr_q + ADDR_W'(1)) : addr_q;
            iss_q  <= go ? len_q : iss_q - LEN_W'(issue);
            out_q  <= go ? len_q : out_q - LEN_W'(pop);
        end
    end
    dircc_skid_buf2 #(.DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .reset_n(reset_n),
        .push_i (infl_q),
        .pop_i  (pop),
        .data_i (bus.mem_readdata),
        .head_o (head),
        .count_o(cnt)
    );
endmodule
